// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side driver for the 8-bit accumulator ALU.
// Takes one op/operand command at a time and drives the ALU control ports.
// It waits ALU_LAT cycles after the ISSUE cycle, then captures the result and
// returns it on a valid/ready response stream. Only one command is ever in flight.
module alu_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_load,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         alu_on,
  output logic [2:0]   alu_in_sel,
  output logic [W-1:0] alu_num1,
  output logic [W-1:0] alu_num2,
  output logic [6:0]   alu_out_sel,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   err_count,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  logic [1:0] state_reg;
  logic [2:0] op_reg;
  logic [3:0] cnt_reg;
  logic       accept;
  logic       rsp_fire;

  // Commands are taken only in IDLE, and never while reset is held.
  assign cmd_ready = (state_reg == S_IDLE) && !rst;
  assign alu_on    = !rst;
  assign busy      = (state_reg != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Control FSM: the operand and selector registers double as the command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= 3'd0;
      cnt_reg     <= 4'd0;
      alu_in_sel  <= 3'b000;
      alu_out_sel <= 7'd0;
      alu_num1    <= '0;
      alu_num2    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= cmd_op;
            state_reg <= S_ISSUE;
            if (cmd_op == OP_CLEAR) begin
              alu_in_sel  <= 3'b100;
              alu_num1    <= '0;
              alu_num2    <= '0;
              alu_out_sel <= 7'd0;
            end else begin
              alu_in_sel  <= cmd_load ? 3'b010 : 3'b001;
              alu_num1    <= cmd_load ? cmd_a : '0;
              alu_num2    <= cmd_b;
              alu_out_sel <= 7'b1 << cmd_op;
            end
          end
        end
        S_ISSUE: begin
          // Input selector is a one-cycle strobe.
          alu_in_sel <= 3'b000;
          cnt_reg    <= LAT_INIT;
          if (op_reg == OP_CLEAR) begin
            // CLEAR has no ALU result to wait for.
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= S_RESP;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            // Counter reaches zero on this edge: capture, then release the ALU controls.
            rsp_data    <= alu_result;
            rsp_err     <= alu_overflow && (op_reg == OP_MULT);
            rsp_valid   <= 1'b1;
            alu_out_sel <= 7'd0;
            alu_num1    <= '0;
            alu_num2    <= '0;
            state_reg   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            state_reg <= S_IDLE;
            if (rsp_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against a
// command-level reference model. dut1 uses ALU_LAT=1 with a behavioural
// accumulator ALU. dut4 uses ALU_LAT=4 with a fixed-value ALU for the latency
// and reset-abandon scenarios.
module tb_alu_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- dut1 (ALU_LAT=1) ----------------
  logic       rst, cmd_valid, cmd_ready, cmd_load, alu_on, alu_overflow;
  logic       rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0] cmd_op, alu_in_sel;
  logic [7:0] cmd_a, cmd_b, alu_num1, alu_num2, alu_result, rsp_data, err_count;
  logic [6:0] alu_out_sel;

  alu_sequencer #(.ALU_LAT(1), .W(8)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  // Behavioural accumulator ALU attached to dut1.
  logic [7:0]  fa_src, fa_last;
  logic [15:0] fa_prod;
  always_comb begin
    fa_prod      = 16'(fa_src) * 16'(alu_num2);
    alu_result   = fa_last;
    alu_overflow = 1'b0;
    case (alu_out_sel)
      7'b0000001: alu_result = fa_src & alu_num2;
      7'b0000010: alu_result = fa_src | alu_num2;
      7'b0000100: alu_result = fa_src ^ alu_num2;
      7'b0001000: alu_result = ~fa_src;
      7'b0010000: alu_result = fa_src + alu_num2;
      7'b0100000: alu_result = fa_src - alu_num2;
      7'b1000000: begin
        alu_result   = fa_prod[7:0];
        alu_overflow = |fa_prod[15:8];
      end
      default: ;
    endcase
  end
  always @(posedge clk) begin
    if (rst || alu_in_sel[2]) begin
      fa_src  <= 8'd0;
      fa_last <= 8'd0;
    end else if (alu_in_sel[1]) fa_src <= alu_num1;
    else if (alu_in_sel[0])     fa_src <= fa_last;
    else if (alu_out_sel != 7'd0) fa_last <= alu_result;
  end

  // ---------------- dut4 (ALU_LAT=4) ----------------
  logic       rst4, cmd_valid4, cmd_ready4, cmd_load4, alu_on4, alu_overflow4;
  logic       rsp_valid4, rsp_ready4, rsp_err4, busy4;
  logic [2:0] cmd_op4, alu_in_sel4;
  logic [7:0] cmd_a4, cmd_b4, alu_num14, alu_num24, alu_result4, rsp_data4, err_count4;
  logic [6:0] alu_out_sel4;

  alu_sequencer #(.ALU_LAT(4), .W(8)) dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op4), .cmd_load(cmd_load4), .cmd_a(cmd_a4), .cmd_b(cmd_b4),
    .alu_on(alu_on4), .alu_in_sel(alu_in_sel4), .alu_num1(alu_num14),
    .alu_num2(alu_num24), .alu_out_sel(alu_out_sel4), .alu_result(alu_result4),
    .alu_overflow(alu_overflow4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_err(rsp_err4), .err_count(err_count4), .busy(busy4)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_prev;
  int         m_errs;
  logic [7:0] last_data;
  logic       last_err;

  task automatic model_cmd(input logic [2:0] op, input logic ld, input logic [7:0] a,
                           input logic [7:0] b, output logic [7:0] ed, output logic ee);
    int x, r;
    x  = ld ? int'(a) : int'(m_prev);
    ee = 1'b0;
    case (op)
      3'd0: r = x & int'(b);
      3'd1: r = x | int'(b);
      3'd2: r = x ^ int'(b);
      3'd3: r = ~x;
      3'd4: r = x + int'(b);
      3'd5: r = x - int'(b);
      3'd6: begin r = x * int'(b); ee = (r > 255); end
      default: r = 0;
    endcase
    ed     = r[7:0];
    m_prev = ed;
  endtask

  // Present one command to dut1; returns in the cycle after the accept edge.
  task automatic send(input logic [2:0] op, input logic ld, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL send_ready: got cmd_ready=%b want 1", cmd_ready); end
    cmd_op = op; cmd_load = ld; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom_range(0, 7)); cmd_a = 8'($urandom_range(0, 255)); cmd_b = 8'($urandom_range(0, 255));
  endtask

  // Wait for the response, hold it off for 'hold' cycles, then consume it.
  task automatic finish(input int start, input int exp_lat, input int hold, input logic [2:0] op,
                        input logic ld, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [7:0] ed, d0;
    logic ee, e0;
    lat = start;
    while (!rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    total++;
    if (rsp_valid !== 1'b1 || lat != exp_lat) begin
      bad++; $display("FAIL latency op=%0d: got rsp_valid=%b after %0d cycles want 1 after %0d", op, rsp_valid, lat, exp_lat);
    end
    model_cmd(op, ld, a, b, ed, ee);
    total++;
    if (rsp_data !== ed) begin bad++; $display("FAIL rsp_data op=%0d: got %h want %h", op, rsp_data, ed); end
    total++;
    if (rsp_err !== ee) begin bad++; $display("FAIL rsp_err op=%0d: got %b want %b", op, rsp_err, ee); end
    d0 = rsp_data; e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom_range(0, 7)); cmd_load = 1'($urandom_range(0, 1));
      cmd_a = 8'($urandom_range(0, 255)); cmd_b = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_err !== e0 || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL hold: got valid=%b data=%h err=%b ready=%b want 1 %h %b 0",
                        rsp_valid, rsp_data, rsp_err, cmd_ready, d0, e0);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    last_data = d0; last_err = e0;
    if (ee && m_errs < 255) m_errs++;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL idle: got busy=%b rsp_valid=%b cmd_ready=%b want 0 0 1", busy, rsp_valid, cmd_ready);
    end
    total++;
    if (err_count !== 8'(m_errs)) begin bad++; $display("FAIL err_count: got %0d want %0d", err_count, m_errs); end
    total++;
    if (alu_out_sel !== 7'd0 || alu_num1 !== 8'd0 || alu_num2 !== 8'd0 || alu_in_sel !== 3'd0) begin
      bad++; $display("FAIL idle_ctrl: got out_sel=%b num1=%h num2=%h in_sel=%b want all 0",
                      alu_out_sel, alu_num1, alu_num2, alu_in_sel);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic ld, input logic [7:0] a, input logic [7:0] b, input int hold);
    send(op, ld, a, b);
    finish(1, (op == 3'd7) ? 2 : 3, hold, op, ld, a, b);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 3'd0; cmd_load = 1'b0;
    cmd_a = 8'd0; cmd_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b0 || alu_on !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got cmd_ready=%b alu_on=%b want 0 0", cmd_ready, alu_on);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_err !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0 ||
        alu_in_sel !== 3'd0 || alu_out_sel !== 7'd0 || alu_num1 !== 8'd0 || alu_num2 !== 8'd0) begin
      bad++; $display("FAIL reset_state: got valid=%b data=%h err=%b cnt=%0d busy=%b in=%b out=%b n1=%h n2=%h want all 0",
                      rsp_valid, rsp_data, rsp_err, err_count, busy, alu_in_sel, alu_out_sel, alu_num1, alu_num2);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || alu_on !== 1'b1) begin
      bad++; $display("FAIL reset_release: got cmd_ready=%b alu_on=%b want 1 1", cmd_ready, alu_on);
    end
    m_prev = 8'd0; m_errs = 0;
  endtask

  task automatic test_add_load;
    send(3'd4, 1'b1, 8'h05, 8'h03);
    total++;
    if (alu_in_sel !== 3'b010 || alu_out_sel !== 7'b0010000 || alu_num1 !== 8'h05 || alu_num2 !== 8'h03 || busy !== 1'b1) begin
      bad++; $display("FAIL add_issue: got in=%b out=%b n1=%h n2=%h busy=%b want 010 0010000 05 03 1",
                      alu_in_sel, alu_out_sel, alu_num1, alu_num2, busy);
    end
    @(posedge clk); #1;
    total++;
    if (alu_in_sel !== 3'b000 || alu_out_sel !== 7'b0010000 || alu_num1 !== 8'h05 || alu_num2 !== 8'h03) begin
      bad++; $display("FAIL add_wait: got in=%b out=%b n1=%h n2=%h want 000 0010000 05 03",
                      alu_in_sel, alu_out_sel, alu_num1, alu_num2);
    end
    finish(2, 3, 0, 3'd4, 1'b1, 8'h05, 8'h03);
    total++;
    if (last_data !== 8'h08) begin bad++; $display("FAIL add_value: got %h want 08", last_data); end
  endtask

  task automatic test_persist;
    run(3'd4, 1'b1, 8'h0A, 8'h14, 0);
    total++;
    if (last_data !== 8'h1E) begin bad++; $display("FAIL persist_first: got %h want 1e", last_data); end
    send(3'd5, 1'b0, 8'hAA, 8'h05);
    total++;
    if (alu_in_sel !== 3'b001 || alu_num1 !== 8'h00 || alu_num2 !== 8'h05 || alu_out_sel !== 7'b0100000) begin
      bad++; $display("FAIL persist_issue: got in=%b n1=%h n2=%h out=%b want 001 00 05 0100000",
                      alu_in_sel, alu_num1, alu_num2, alu_out_sel);
    end
    finish(1, 3, 0, 3'd5, 1'b0, 8'hAA, 8'h05);
    total++;
    if (last_data !== 8'h19) begin bad++; $display("FAIL persist_value: got %h want 19", last_data); end
  endtask

  task automatic test_mult_overflow;
    run(3'd6, 1'b1, 8'h20, 8'h10, 0);
    total++;
    if (last_err !== 1'b1 || err_count !== 8'd1) begin
      bad++; $display("FAIL mult_first: got err=%b count=%0d want 1 1", last_err, err_count);
    end
    for (int i = 0; i < 300; i++) run(3'd6, 1'b1, 8'h20, 8'h10, 0);
    total++;
    if (err_count !== 8'd255) begin bad++; $display("FAIL mult_saturate: got %0d want 255", err_count); end
  endtask

  task automatic test_backpressure;
    run(3'd2, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL bp_no_extra: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
      end
    end
  endtask

  task automatic test_clear;
    send(3'd7, 1'b1, 8'hFF, 8'hFF);
    total++;
    if (alu_in_sel !== 3'b100 || alu_num1 !== 8'd0 || alu_num2 !== 8'd0 || alu_out_sel !== 7'd0) begin
      bad++; $display("FAIL clear_issue: got in=%b n1=%h n2=%h out=%b want 100 00 00 0",
                      alu_in_sel, alu_num1, alu_num2, alu_out_sel);
    end
    @(posedge clk); #1;
    total++;
    if (alu_in_sel !== 3'b000 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL clear_next: got in=%b rsp_valid=%b want 000 1", alu_in_sel, rsp_valid);
    end
    finish(2, 2, 0, 3'd7, 1'b1, 8'hFF, 8'hFF);
    run(3'd4, 1'b0, 8'h55, 8'h09, 0);
  endtask

  task automatic test_random;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      run(op, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    cmd_valid4 = 1'b0; rsp_ready4 = 1'b0; cmd_load4 = 1'b1; cmd_a4 = 8'h20; cmd_b4 = 8'h10; cmd_op4 = 3'd6;
    alu_result4 = 8'hC3; alu_overflow4 = 1'b1;
    rst4 = 1'b0;
    #1;
    // Overflowing MULT first, so there is an error count for the reset to clear.
    cmd_valid4 = 1'b1;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    lat = 1;
    while (!rsp_valid4 && lat < 60) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 6 || rsp_data4 !== 8'hC3 || rsp_err4 !== 1'b1) begin
      bad++; $display("FAIL lat4: got lat=%0d data=%h err=%b want 6 c3 1", lat, rsp_data4, rsp_err4);
    end
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;
    rsp_ready4 = 1'b0;
    total++;
    if (err_count4 !== 8'd1) begin bad++; $display("FAIL lat4_count: got %0d want 1", err_count4); end
    // Second command, abandoned by reset while in WAIT.
    cmd_op4 = 3'd4; cmd_valid4 = 1'b1;
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy4 !== 1'b1 || alu_in_sel4 !== 3'd0 || alu_out_sel4 !== 7'b0010000) begin
      bad++; $display("FAIL mid_wait: got busy=%b in=%b out=%b want 1 000 0010000", busy4, alu_in_sel4, alu_out_sel4);
    end
    rst4 = 1'b1;
    #1;
    total++;
    if (cmd_ready4 !== 1'b0 || alu_on4 !== 1'b0) begin
      bad++; $display("FAIL rst4_hold: got cmd_ready=%b alu_on=%b want 0 0", cmd_ready4, alu_on4);
    end
    @(posedge clk); #1;
    rst4 = 1'b0;
    #1;
    total++;
    if (cmd_ready4 !== 1'b1 || alu_on4 !== 1'b1 || busy4 !== 1'b0 || rsp_valid4 !== 1'b0 || err_count4 !== 8'd0 ||
        alu_in_sel4 !== 3'd0 || alu_out_sel4 !== 7'd0 || alu_num14 !== 8'd0 || alu_num24 !== 8'd0) begin
      bad++; $display("FAIL rst4_after: got rdy=%b on=%b busy=%b v=%b cnt=%0d in=%b out=%b n1=%h n2=%h want 1 1 0 0 0 0 0 0 0",
                      cmd_ready4, alu_on4, busy4, rsp_valid4, err_count4, alu_in_sel4, alu_out_sel4, alu_num14, alu_num24);
    end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid4 === 1'b1) lat++;
    end
    total++;
    if (lat != 0) begin bad++; $display("FAIL rst4_no_rsp: got %0d rsp_valid cycles want 0", lat); end
  endtask

  initial begin
    rst4 = 1'b1; cmd_valid4 = 1'b0; rsp_ready4 = 1'b0; cmd_op4 = 3'd0; cmd_load4 = 1'b0;
    cmd_a4 = 8'd0; cmd_b4 = 8'd0; alu_result4 = 8'd0; alu_overflow4 = 1'b0;
    last_data = 8'd0; last_err = 1'b0;
    test_reset;
    test_add_load;
    test_persist;
    test_mult_overflow;
    test_backpressure;
    test_clear;
    test_random;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
